// File: rtl/ov7670_capture_ctrl.sv
// OV7670 frame-capture sequencer: gates the deserializer, turns pixel strobes into
// frame-buffer writes and checks line/frame geometry. Define DOWNSCALE_2X_EN for 2x decimation.
module ov7670_capture_ctrl #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              PCLK,
  input  logic              RST_N,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic              PIX_VALID,
  input  logic [11:0]       PIX,
  input  logic              START,
  input  logic              CONT,
  input  logic              STOP,
  output logic              CAP_EN,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [11:0]       WR_DATA,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              LINE_ERR,
  output logic              FRAME_ERR
);
  localparam int COL_W = $clog2(H_ACTIVE + 2);
  localparam int ROW_W = $clog2(V_ACTIVE + 2);
  localparam logic [COL_W-1:0] COL_END = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] COL_SAT = COL_W'(H_ACTIVE + 1);
  localparam logic [ROW_W-1:0] ROW_END = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] ROW_SAT = ROW_W'(V_ACTIVE + 1);
`ifdef DOWNSCALE_2X_EN
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE / 2);
`else
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);
`endif

  typedef enum logic [1:0] {IDLE, SYNC, CAPT, DONE} state_t;
  state_t state, state_nx;

  logic              vs_q, href_q, line_pend, cont_q, stop_q;
  logic              vs_fall, vs_rise, href_fall;
  logic              pix_in, pix_wr, line_end, base_step;
  logic [COL_W-1:0]  col, col_eff;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr, line_base;

  assign vs_fall   = vs_q & ~VSYNC;
  assign vs_rise   = ~vs_q & VSYNC;
  assign href_fall = href_q & ~HREF;
  assign pix_in    = (state == CAPT) && PIX_VALID;
  assign line_end  = (state == CAPT) && line_pend;
  // col including this cycle's pixel, so a late pixel lands before the line check
  assign col_eff   = (pix_in && col != COL_SAT) ? col + 1'b1 : col;

`ifdef DOWNSCALE_2X_EN
  assign pix_wr    = pix_in && col < COL_END && row < ROW_END && !col[0] && !row[0];
  assign base_step = row[0] && row < ROW_END;
`else
  assign pix_wr    = pix_in && col < COL_END && row < ROW_END;
  assign base_step = row < ROW_END;
`endif

  always_ff @(posedge PCLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (START && !STOP) state_nx = SYNC;
      SYNC: if (STOP) state_nx = IDLE;
            else if (vs_fall) state_nx = CAPT;
      CAPT: if (vs_rise) state_nx = DONE;
      DONE: state_nx = (!cont_q || stop_q || STOP) ? IDLE : SYNC;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    CAP_EN     = 1'b0;
    BUSY       = 1'b1;
    FRAME_DONE = 1'b0;
    case (state)
      IDLE:    BUSY       = 1'b0;
      CAPT:    CAP_EN     = 1'b1;
      DONE:    FRAME_DONE = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or negedge RST_N)
    if (!RST_N) begin
      vs_q <= 1'b0; href_q <= 1'b0; line_pend <= 1'b0;
      cont_q <= 1'b0; stop_q <= 1'b0;
      col <= '0; row <= '0; addr <= '0; line_base <= '0;
      WR_EN <= 1'b0; WR_ADDR <= '0; WR_DATA <= '0;
      LINE_ERR <= 1'b0; FRAME_ERR <= 1'b0;
    end else begin
      vs_q      <= VSYNC;
      href_q    <= HREF;
      line_pend <= (state == CAPT) && href_fall;
      WR_EN     <= pix_wr;
      if (pix_wr) begin
        WR_ADDR <= addr;
        WR_DATA <= PIX;
      end
      case (state)
        IDLE: begin
          stop_q <= 1'b0;
          if (START && !STOP) begin
            cont_q    <= CONT;
            LINE_ERR  <= 1'b0;
            FRAME_ERR <= 1'b0;
          end
        end
        SYNC: begin
          col <= '0; row <= '0; addr <= '0; line_base <= '0;
        end
        CAPT: begin
          if (STOP) stop_q <= 1'b1;
          if (line_end) begin
            if (col_eff != COL_END) LINE_ERR <= 1'b1;
            col <= '0;
            if (row != ROW_SAT) row <= row + 1'b1;
            // line_base tracks the first buffer address of the next written line
            if (base_step) begin
              line_base <= line_base + LINE_STEP;
              addr      <= line_base + LINE_STEP;
            end else begin
              addr      <= line_base;
            end
          end else begin
            col <= col_eff;
            if (pix_wr) addr <= addr + 1'b1;
          end
        end
        DONE: if (row != ROW_END) FRAME_ERR <= 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Bench for ov7670_capture_ctrl: frame-level vector table plus reset / START-STOP
// sequences; every accepted pixel is predicted into a queue and matched against the write port.
module tb_ov7670_capture_ctrl;
  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 6;

  logic PCLK = 1'b0, RST_N = 1'b0, VSYNC = 1'b1, HREF = 1'b0, PIX_VALID = 1'b0;
  logic START = 1'b0, CONT = 1'b0, STOP = 1'b0;
  logic [11:0] PIX = '0;
  logic CAP_EN, WR_EN, BUSY, FRAME_DONE, LINE_ERR, FRAME_ERR;
  logic [AW-1:0] WR_ADDR;
  logic [11:0]   WR_DATA;

  int checks = 0, errors = 0, done_cnt = 0;
  logic [AW+11:0] exp_q[$];
  logic [AW+11:0] sb_e;

  typedef struct {
    bit start; bit cont; int nlines; int odd_row; int odd_len; int skew_row; int mid;
    bit cap; int exp_done; bit exp_busy; bit exp_lerr; bit exp_ferr;
  } vec_t;
  vec_t tbl[11];
  vec_t v;

  always #5 PCLK = ~PCLK;

  ov7670_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .PCLK(PCLK), .RST_N(RST_N), .VSYNC(VSYNC), .HREF(HREF), .PIX_VALID(PIX_VALID),
    .PIX(PIX), .START(START), .CONT(CONT), .STOP(STOP), .CAP_EN(CAP_EN), .WR_EN(WR_EN),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE),
    .LINE_ERR(LINE_ERR), .FRAME_ERR(FRAME_ERR)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_addr(input int r, input int c);
`ifdef DOWNSCALE_2X_EN
    return (r / 2) * (H / 2) + c / 2;
`else
    return r * H + c;
`endif
  endfunction

  function automatic bit exp_wr(input int r, input int c);
`ifdef DOWNSCALE_2X_EN
    return c < H && r < V && (c % 2 == 0) && (r % 2 == 0);
`else
    return c < H && r < V;
`endif
  endfunction

  // scoreboard: every write must match the oldest predicted pixel
  always @(negedge PCLK) if (RST_N) begin
    if (FRAME_DONE) done_cnt++;
    if (WR_EN) begin
      if (exp_q.size() == 0) chk("unexpected_write", int'(WR_EN), 0);
      else begin
        sb_e = exp_q.pop_front();
        chk("wr_addr", int'(WR_ADDR), int'(sb_e[AW+11:12]));
        chk("wr_data", int'(WR_DATA), int'(sb_e[11:0]));
      end
    end
  end

  // one line: HREF for n cycles, pixel strobes delayed by skew cycles
  task automatic line(input int r, input int n, input int skew, input bit cap);
    int c;
    c = 0;
    for (int i = 0; i < n + skew + 2; i++) begin
      @(negedge PCLK);
      HREF      = (i < n);
      PIX_VALID = (i >= skew && i < n + skew);
      if (PIX_VALID) begin
        PIX = 12'($urandom);
        if (cap && exp_wr(r, c)) exp_q.push_back({AW'(exp_addr(r, c)), PIX});
        c++;
      end
    end
    @(negedge PCLK);
    HREF = 1'b0; PIX_VALID = 1'b0;
  endtask

  task automatic frame(input vec_t f);
    @(negedge PCLK); VSYNC = 1'b0;
    repeat (2) @(negedge PCLK);
    for (int r = 0; r < f.nlines; r++) begin
      line(r, (r == f.odd_row) ? f.odd_len : H, (r == f.skew_row) ? 2 : 1, f.cap);
      if (r == f.odd_row && f.cap) chk("line_err_after_bad_line", int'(LINE_ERR), 1);
      if (r == 1 && f.mid == 1) begin STOP = 1'b1; @(negedge PCLK); STOP = 1'b0; end
      if (r == 1 && f.mid == 2) begin START = 1'b1; CONT = 1'b0; @(negedge PCLK); START = 1'b0; end
    end
    repeat (2) @(negedge PCLK);
    VSYNC = 1'b1;
    repeat (4) @(negedge PCLK);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cap_en"}, int'(CAP_EN), 0);
    chk({tag, "_wr_en"}, int'(WR_EN), 0);
    chk({tag, "_wr_addr"}, int'(WR_ADDR), 0);
    chk({tag, "_wr_data"}, int'(WR_DATA), 0);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_frame_done"}, int'(FRAME_DONE), 0);
    chk({tag, "_line_err"}, int'(LINE_ERR), 0);
    chk({tag, "_frame_err"}, int'(FRAME_ERR), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    //          st cont nl odd len   skew mid cap done busy lerr ferr
    tbl[0]  = '{1, 0,   6, -1, 0,    -1,  0,  1,  1,   0,   0,   0};
    tbl[1]  = '{1, 0,   6,  3, H-1,  -1,  0,  1,  1,   0,   1,   0};
    tbl[2]  = '{1, 0,   6, -1, 0,     2,  0,  1,  1,   0,   0,   0};
    tbl[3]  = '{1, 0,   6,  1, H+3,  -1,  0,  1,  1,   0,   1,   0};
    tbl[4]  = '{1, 0,   5, -1, 0,    -1,  0,  1,  1,   0,   0,   1};
    tbl[5]  = '{1, 0,   8, -1, 0,    -1,  0,  1,  1,   0,   0,   1};
    tbl[6]  = '{1, 1,   6, -1, 0,    -1,  0,  1,  1,   1,   0,   0};
    tbl[7]  = '{0, 0,   6, -1, 0,    -1,  1,  1,  1,   0,   0,   0};
    tbl[8]  = '{0, 0,   6, -1, 0,    -1,  0,  0,  0,   0,   0,   0};
    tbl[9]  = '{0, 0,   6, -1, 0,    -1,  2,  0,  0,   1,   0,   0};
    tbl[10] = '{0, 0,   6, -1, 0,    -1,  0,  1,  1,   0,   0,   0};

    // reset state, then a reset in the middle of a capture
    repeat (2) @(negedge PCLK);
    chk_all_zero("reset");
    RST_N = 1'b1;
    @(negedge PCLK); START = 1'b1; CONT = 1'b0;
    @(negedge PCLK); START = 1'b0; VSYNC = 1'b0;
    repeat (2) @(negedge PCLK);
    line(0, H, 1, 1'b1);
    chk("mid_capt_busy", int'(BUSY), 1);
    chk("mid_capt_cap_en", int'(CAP_EN), 1);
    RST_N = 1'b0;
    repeat (3) @(negedge PCLK);
    chk_all_zero("in_reset");
    RST_N = 1'b1;
    line(1, H, 1, 1'b0);
    @(negedge PCLK); VSYNC = 1'b1;
    repeat (3) @(negedge PCLK);
    d0 = done_cnt;
    v = '{0, 0, 6, -1, 0, -1, 0, 0, 0, 0, 0, 0};
    frame(v);
    chk("no_start_done", done_cnt - d0, 0);
    chk("no_start_busy", int'(BUSY), 0);

    for (int i = 0; i < 11; i++) begin
      d0 = done_cnt;
      if (tbl[i].start) begin
        @(negedge PCLK); START = 1'b1; CONT = tbl[i].cont;
        @(negedge PCLK); START = 1'b0; CONT = 1'b0;
      end
      frame(tbl[i]);
      chk($sformatf("v%0d_frame_done", i), done_cnt - d0, tbl[i].exp_done);
      chk($sformatf("v%0d_busy", i), int'(BUSY), int'(tbl[i].exp_busy));
      chk($sformatf("v%0d_line_err", i), int'(LINE_ERR), int'(tbl[i].exp_lerr));
      chk($sformatf("v%0d_frame_err", i), int'(FRAME_ERR), int'(tbl[i].exp_ferr));
    end

    // START and STOP together in IDLE must not arm capture
    @(negedge PCLK); START = 1'b1; STOP = 1'b1; CONT = 1'b1;
    @(negedge PCLK); START = 1'b0; STOP = 1'b0; CONT = 1'b0;
    @(negedge PCLK);
    chk("start_stop_busy", int'(BUSY), 0);
    d0 = done_cnt;
    v = '{0, 0, 6, -1, 0, -1, 0, 0, 0, 0, 0, 0};
    frame(v);
    chk("start_stop_done", done_cnt - d0, 0);

    repeat (3) @(negedge PCLK);
    chk("pending_writes", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
